// File: rtl/esfa_op_scheduler_if.sv
// Requester, response and core-side signal bundle for esfa_op_scheduler.
// The master modport is the requester/core side, the slave modport is the scheduler.
interface esfa_op_scheduler_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    reqValid;
    logic [NUM_REQ*32-1:0] reqData;
    logic [NUM_REQ*2-1:0]  reqCtrl;
    logic [NUM_REQ-1:0]    reqReady;
    logic                  rspValid;
    logic [1:0]            rspId;
    logic                  rspBool;
    logic [7:0]            rspValue;
    logic                  rspAck;
    logic [7:0]            coreIndex;
    logic [7:0]            coreValue;
    logic [7:0]            coreMetadata;
    logic                  coreIsMetadata;
    logic [7:0]            coreSelector;
    logic                  coreResultBool;
    logic [7:0]            coreResultValue;
    logic [23:0]           rspCycles;

    modport master (
        output reqValid, reqData, reqCtrl, rspAck, coreResultBool, coreResultValue,
        input  reqReady, rspValid, rspId, rspBool, rspValue,
               coreIndex, coreValue, coreMetadata, coreIsMetadata, coreSelector, rspCycles
    );

    modport slave (
        input  reqValid, reqData, reqCtrl, rspAck, coreResultBool, coreResultValue,
        output reqReady, rspValid, rspId, rspBool, rspValue,
               coreIndex, coreValue, coreMetadata, coreIsMetadata, coreSelector, rspCycles
    );
endinterface

// File: rtl/esfa_op_scheduler.sv
// Round-robin scheduler sharing one ESFADesign core: grant, selector hold, settle, capture, respond.
// Optional busy-cycle counter on rspCycles enabled by defining ESFA_SCHED_CYCLE_COUNT_EN.
module esfa_op_scheduler #(
    parameter int         NUM_REQ       = 2,
    parameter int         HOLD_CYCLES   = 2,
    parameter int         SETTLE_CYCLES = 3,
    parameter logic [7:0] IDLE_SEL      = 8'd8
) (
    input  logic              masterClock,
    input  logic              reset,
    esfa_op_scheduler_if.slave bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
        S_SETTLE  = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_last;
    logic                 r_is_mut;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic                 r_rsp_valid;
    logic [1:0]           r_rsp_id;
    logic                 r_rsp_bool;
    logic [7:0]           r_rsp_value;
    logic [7:0]           r_core_index;
    logic [7:0]           r_core_value;
    logic [7:0]           r_core_meta;
    logic                 r_core_is_meta;
    logic [7:0]           r_core_sel;

    logic [3:0]           w_valid_pad;
    logic [127:0]         w_data_pad;
    logic [7:0]           w_ctrl_pad;
    logic                 w_gnt_any;
    logic [1:0]           w_gnt_idx;
    logic [31:0]          w_gnt_data;
    logic [1:0]           w_gnt_ctrl;

    // Padding to four requesters keeps every index a fixed 2-bit value.
    assign w_valid_pad = 4'(bus.reqValid);
    assign w_data_pad  = 128'(bus.reqData);
    assign w_ctrl_pad  = 8'(bus.reqCtrl);

    function automatic logic [1:0] rr_idx(input logic [1:0] last, input int k);
        int s;
        s = int'(last) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[1:0];
    endfunction

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_gnt_any && w_valid_pad[rr_idx(r_last, k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = rr_idx(r_last, k);
            end
        end
    end

    assign w_gnt_data = w_data_pad[w_gnt_idx*32 +: 32];
    assign w_gnt_ctrl = w_ctrl_pad[w_gnt_idx*2 +: 2];

    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_last         <= 2'(NUM_REQ - 1);
            r_is_mut       <= 1'b0;
            r_req_ready    <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 2'd0;
            r_rsp_bool     <= 1'b0;
            r_rsp_value    <= 8'd0;
            r_core_index   <= 8'd0;
            r_core_value   <= 8'd0;
            r_core_meta    <= 8'd0;
            r_core_is_meta <= 1'b0;
            r_core_sel     <= IDLE_SEL;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_req_ready    <= NUM_REQ'(1) << w_gnt_idx;
                        r_core_index   <= w_gnt_data[7:0];
                        r_core_value   <= w_gnt_data[15:8];
                        r_core_meta    <= w_gnt_data[23:16];
                        r_core_is_meta <= w_gnt_ctrl[1];
                        r_is_mut       <= w_gnt_ctrl[0];
                        r_last         <= w_gnt_idx;
                        r_rsp_id       <= w_gnt_idx;
                        if (w_gnt_ctrl[0]) begin
                            r_core_sel <= w_gnt_data[31:24];
                            r_cnt      <= HOLD_LOAD;
                            r_state    <= S_HOLD;
                        end else begin
                            r_cnt      <= SETTLE_LOAD;
                            r_state    <= S_SETTLE;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
                        r_core_sel <= IDLE_SEL;
                        r_cnt      <= SETTLE_LOAD;
                        r_state    <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_bool  <= r_is_mut ? 1'b1 : bus.coreResultBool;
                        r_rsp_value <= r_is_mut ? 8'd0 : bus.coreResultValue;
                        r_state     <= S_RESPOND;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (bus.rspAck) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ESFA_SCHED_CYCLE_COUNT_EN
    logic [23:0] r_cyc;
    logic [23:0] r_rsp_cycles;

    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        return (v == 24'hFFFFFF) ? v : v + 24'd1;
    endfunction

    always_ff @(posedge masterClock or negedge reset) begin
        if (!reset) begin
            r_cyc        <= 24'd0;
            r_rsp_cycles <= 24'd0;
        end else begin
            if (r_state == S_IDLE && w_gnt_any)
                r_cyc <= 24'd0;
            else if (r_state == S_HOLD || r_state == S_SETTLE)
                r_cyc <= sat_inc(r_cyc);
            if (r_state == S_SETTLE && r_cnt == '0)
                r_rsp_cycles <= sat_inc(r_cyc);
        end
    end

    assign bus.rspCycles = r_rsp_cycles;
`else
    assign bus.rspCycles = 24'h0;
`endif

    assign bus.reqReady       = r_req_ready;
    assign bus.rspValid       = r_rsp_valid;
    assign bus.rspId          = r_rsp_id;
    assign bus.rspBool        = r_rsp_bool;
    assign bus.rspValue       = r_rsp_value;
    assign bus.coreIndex      = r_core_index;
    assign bus.coreValue      = r_core_value;
    assign bus.coreMetadata   = r_core_meta;
    assign bus.coreIsMetadata = r_core_is_meta;
    assign bus.coreSelector   = r_core_sel;
endmodule

// File: tb/tb_esfa_op_scheduler.sv
// Directed bench for esfa_op_scheduler: query, mutate, round-robin, held response, mid-op reset.
module tb_esfa_op_scheduler;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

`ifdef ESFA_SCHED_CYCLE_COUNT_EN
    localparam logic [23:0] CYC_Q = 24'd3;
    localparam logic [23:0] CYC_M = 24'd5;
`else
    localparam logic [23:0] CYC_Q = 24'd0;
    localparam logic [23:0] CYC_M = 24'd0;
`endif

    esfa_op_scheduler_if #(.NUM_REQ(2)) bus ();

    esfa_op_scheduler #(
        .NUM_REQ(2), .HOLD_CYCLES(2), .SETTLE_CYCLES(3), .IDLE_SEL(8'd8)
    ) dut (
        .masterClock(clk),
        .reset      (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && bus.reqReady == 2'b00; i++) tick();
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 20 && bus.rspValid !== 1'b1; i++) tick();
    endtask

    task automatic ack();
        bus.rspAck = 1'b1;
        tick();
        bus.rspAck = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.reqValid = 2'b00;
        bus.reqData = 64'h0;
        bus.reqCtrl = 4'b0000;
        bus.rspAck = 1'b0;
        bus.coreResultBool = 1'b0;
        bus.coreResultValue = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", bus.coreSelector, 8'd8);
        chk("rst_rspValid", bus.rspValid, 1'b0);
        chk("rst_reqReady", bus.reqReady, 2'b00);
        chk("rst_rspId", bus.rspId, 2'd0);
        chk("rst_coreIndex", bus.coreIndex, 8'd0);
        chk("rst_rspCycles", bus.rspCycles, 24'd0);
        rst_n = 1'b1;
        tick();

        // Query from req0
        bus.coreResultValue = 8'h5A;
        bus.coreResultBool = 1'b1;
        bus.reqData[31:0] = 32'hAA_BB_CC_DD;
        bus.reqCtrl[1:0] = 2'b00;
        bus.reqValid = 2'b01;
        tick();
        bus.reqValid = 2'b00;
        chk("q_ready", bus.reqReady, 2'b01);
        chk("q_sel", bus.coreSelector, 8'd8);
        chk("q_index", bus.coreIndex, 8'hDD);
        chk("q_value", bus.coreValue, 8'hCC);
        chk("q_meta", bus.coreMetadata, 8'hBB);
        chk("q_ismeta", bus.coreIsMetadata, 1'b0);
        tick();
        chk("q_ready_e1", bus.reqReady, 2'b00);
        chk("q_valid_e1", bus.rspValid, 1'b0);
        tick();
        chk("q_valid_e2", bus.rspValid, 1'b0);
        tick();
        chk("q_valid_e3", bus.rspValid, 1'b1);
        chk("q_id", bus.rspId, 2'd0);
        chk("q_rspValue", bus.rspValue, 8'h5A);
        chk("q_rspBool", bus.rspBool, 1'b1);
        chk("q_cycles", bus.rspCycles, CYC_Q);
        ack();
        chk("q_acked", bus.rspValid, 1'b0);

        // Mutate from req1
        bus.coreResultValue = 8'h77;
        bus.coreResultBool = 1'b0;
        bus.reqData[63:32] = 32'h03_11_22_07;
        bus.reqCtrl[3:2] = 2'b11;
        bus.reqValid = 2'b10;
        tick();
        bus.reqValid = 2'b00;
        chk("m_ready", bus.reqReady, 2'b10);
        chk("m_sel_e0", bus.coreSelector, 8'd3);
        chk("m_index", bus.coreIndex, 8'h07);
        chk("m_value", bus.coreValue, 8'h22);
        chk("m_meta", bus.coreMetadata, 8'h11);
        chk("m_ismeta", bus.coreIsMetadata, 1'b1);
        tick();
        chk("m_sel_e1", bus.coreSelector, 8'd3);
        tick();
        chk("m_sel_e2", bus.coreSelector, 8'd8);
        tick();
        tick();
        chk("m_valid_e4", bus.rspValid, 1'b0);
        tick();
        chk("m_valid_e5", bus.rspValid, 1'b1);
        chk("m_rspBool", bus.rspBool, 1'b1);
        chk("m_rspValue", bus.rspValue, 8'h00);
        chk("m_id", bus.rspId, 2'd1);
        chk("m_cycles", bus.rspCycles, CYC_M);
        chk("m_index_hold", bus.coreIndex, 8'h07);
        ack();

        // Both requesters held valid: grants must alternate 0,1,0,1
        bus.reqCtrl = 4'b0000;
        bus.reqValid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_ready();
            chk("rr_ready", bus.reqReady, (n % 2 == 0) ? 2'b01 : 2'b10);
            wait_rsp();
            chk("rr_id", bus.rspId, 2'(n % 2));
            ack();
        end
        bus.reqValid = 2'b00;

        // Response withheld for 10 cycles while req0 stays valid
        bus.coreResultValue = 8'hC3;
        bus.coreResultBool = 1'b0;
        bus.reqValid = 2'b01;
        wait_ready();
        chk("h_ready", bus.reqReady, 2'b01);
        wait_rsp();
        bus.coreResultValue = 8'h3C;
        for (int n = 0; n < 10; n++) begin
            chk("h_valid", bus.rspValid, 1'b1);
            chk("h_value", bus.rspValue, 8'hC3);
            chk("h_noready", bus.reqReady, 2'b00);
            tick();
        end
        ack();
        chk("h_ack_valid", bus.rspValid, 1'b0);
        chk("h_ack_noready", bus.reqReady, 2'b00);
        tick();
        chk("h_regrant", bus.reqReady, 2'b01);
        bus.reqValid = 2'b00;
        wait_rsp();
        chk("h_rsp2_value", bus.rspValue, 8'h3C);
        ack();

        // Reset during HOLD of a mutate with selector 5
        bus.reqData[63:32] = 32'h05_00_00_01;
        bus.reqCtrl[3:2] = 2'b01;
        bus.reqValid = 2'b10;
        tick();
        bus.reqValid = 2'b00;
        chk("r_ready", bus.reqReady, 2'b10);
        chk("r_sel_e0", bus.coreSelector, 8'd5);
        tick();
        chk("r_sel_e1", bus.coreSelector, 8'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_async_sel", bus.coreSelector, 8'd8);
        chk("r_async_valid", bus.rspValid, 1'b0);
        chk("r_async_index", bus.coreIndex, 8'd0);
        bus.reqCtrl = 4'b0000;
        bus.reqValid = 2'b11;
        tick();
        rst_n = 1'b1;
        tick();
        chk("r_first_grant", bus.reqReady, 2'b01);
        bus.reqValid = 2'b00;
        wait_rsp();
        chk("r_rsp_id", bus.rspId, 2'd0);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
